// File: rtl/awb_gain_gen_pkg.sv
// Shared ISP definitions: channel codes, unity gain and the AWB gain FSM encoding.
// Also used by the white-balance stage that consumes these gains.
package awb_gain_gen_pkg;

   typedef enum logic [1:0] {
      RED   = 2'd0,
      GREEN = 2'd1,
      BLUE  = 2'd2,
      RSVD  = 2'd3
   } color_e;

   localparam logic [7:0] UNITY_GAIN = 8'h10;
   localparam int         DIV_BITS   = 8;

   typedef enum logic [2:0] {
      ACCUM,
      CHK_R,
      DIV_R,
      CHK_B,
      DIV_B,
      PUBLISH
   } awb_state_e;

   // A zero divisor means "no information" and falls back to unity; otherwise the ratio overflowed.
   function automatic logic [7:0] specialGain(input logic divisorZero);
      return divisorZero ? UNITY_GAIN : 8'hFF;
   endfunction

endpackage

// File: rtl/awb_gain_gen_div8.sv
// Restoring divider producing an 8-bit quotient, one bit per cycle, MSB first.
// The caller guarantees dividend < divisor*256 so the quotient fits in 8 bits.
module awb_div8
   import awb_gain_gen_pkg::*;
#(
   parameter int SUM_W = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [SUM_W+3:0] dividend_i,
   input  logic [SUM_W-1:0] divisor_i,
   output logic [7:0]       quotient_o,
   output logic             done_o
);

   localparam int RW = SUM_W + 8;

   logic [RW-1:0] rem_q, rem_d;
   logic [RW-1:0] dsh_q, dsh_d;
   logic [7:0]    quot_q, quot_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          fits;

   // The divisor starts aligned to quotient bit 7 and walks right one place per iteration.
   always_comb begin
      rem_d  = rem_q;
      dsh_d  = dsh_q;
      quot_d = quot_q;
      cnt_d  = cnt_q;
      fits   = (rem_q >= dsh_q);
      if (start_i) begin
         rem_d  = {4'b0, dividend_i};
         dsh_d  = {1'b0, divisor_i, 7'b0};
         quot_d = '0;
         cnt_d  = 4'(DIV_BITS);
      end else if (cnt_q != 4'd0) begin
         if (fits) begin
            rem_d = rem_q - dsh_q;
         end
         dsh_d  = dsh_q >> 1;
         quot_d = {quot_q[6:0], fits};
         cnt_d  = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         dsh_q  <= '0;
         quot_q <= '0;
         cnt_q  <= '0;
      end else begin
         rem_q  <= rem_d;
         dsh_q  <= dsh_d;
         quot_q <= quot_d;
         cnt_q  <= cnt_d;
      end
   end

   // High in the cycle whose closing edge produces the final quotient bit.
   assign done_o     = (cnt_q == 4'd1);
   assign quotient_o = quot_q;

endmodule

// File: rtl/awb_gain_gen.sv
// Auto-white-balance gain generator: accumulates per-channel frame sums and
// derives Q4.4 red/blue gains relative to green with a shared serial divider.
module awb_gain_gen
   import awb_gain_gen_pkg::*;
#(
   parameter int SUM_W   = 28,
   parameter int G_SHIFT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       valid_i,
   input  logic [1:0] color_i,
   input  logic [7:0] value_i,
   input  logic       eof_i,
   output logic [7:0] k_r_o,
   output logic [7:0] k_g_o,
   output logic [7:0] k_b_o,
   output logic       valid_gain_o,
   output logic       gain_upd_o,
   output logic       busy_o,
   output logic       stat_drop_o
);

   awb_state_e state_q, state_d;

   logic [SUM_W-1:0] sumR_q, sumG_q, sumB_q;
   logic [SUM_W-1:0] sumR_d, sumG_d, sumB_d;
   logic [SUM_W-1:0] sumRNext, sumGNext, sumBNext;
   logic [SUM_W-1:0] gs_q, rs_q, bs_q;
   logic             eofAcc;

   logic [7:0]       rRes_q, bRes_q, kR_q, kB_q;
   logic             rSpec_q, bSpec_q;
   logic             validGain_q, gainUpd_q, statDrop_q;

   logic             divStart, divDone;
   logic [SUM_W-1:0] chkDivisor;
   logic [7:0]       divQuot;
   logic             chkZero, chkSat;

   function automatic logic [SUM_W-1:0] satAdd(input logic [SUM_W-1:0] a, input logic [7:0] v);
      logic [SUM_W:0] s;
      s = {1'b0, a} + {{(SUM_W-7){1'b0}}, v};
      return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
   endfunction

   // Accumulate the current sample first so an eof sample is part of its own frame's snapshot.
   always_comb begin
      eofAcc   = valid_i & eof_i;
      sumRNext = sumR_q;
      sumGNext = sumG_q;
      sumBNext = sumB_q;
      if (valid_i && color_i == RED)   sumRNext = satAdd(sumR_q, value_i);
      if (valid_i && color_i == GREEN) sumGNext = satAdd(sumG_q, value_i);
      if (valid_i && color_i == BLUE)  sumBNext = satAdd(sumB_q, value_i);
      sumR_d = eofAcc ? '0 : sumRNext;
      sumG_d = eofAcc ? '0 : sumGNext;
      sumB_d = eofAcc ? '0 : sumBNext;
   end

   always_comb begin
      state_d  = state_q;
      divStart = 1'b0;
      unique case (state_q)
         ACCUM:   if (eofAcc) state_d = CHK_R;
         CHK_R:   begin divStart = 1'b1; state_d = DIV_R; end
         DIV_R:   if (divDone) state_d = CHK_B;
         CHK_B:   begin divStart = 1'b1; state_d = DIV_B; end
         DIV_B:   if (divDone) state_d = PUBLISH;
         PUBLISH: state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   // Gs*16 >= divisor*256 means the ratio would not fit in Q4.4.
   always_comb begin
      chkDivisor = (state_q == CHK_B) ? bs_q : rs_q;
      chkZero    = (chkDivisor == '0);
      chkSat     = ({4'b0, gs_q, 4'b0} >= {chkDivisor, 8'b0});
   end

   awb_div8 #(.SUM_W(SUM_W)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (divStart),
      .dividend_i ({gs_q, 4'b0}),
      .divisor_i  (chkDivisor),
      .quotient_o (divQuot),
      .done_o     (divDone)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         sumR_q  <= '0;
         sumG_q  <= '0;
         sumB_q  <= '0;
         gs_q    <= '0;
         rs_q    <= '0;
         bs_q    <= '0;
      end else begin
         state_q <= state_d;
         sumR_q  <= sumR_d;
         sumG_q  <= sumG_d;
         sumB_q  <= sumB_d;
         if (eofAcc && state_q == ACCUM) begin
            gs_q <= sumGNext >> G_SHIFT;
            rs_q <= sumRNext;
            bs_q <= sumBNext;
         end
      end
   end

   // The red quotient is parked during CHK_B so both gains are released together in PUBLISH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rRes_q      <= UNITY_GAIN;
         bRes_q      <= UNITY_GAIN;
         rSpec_q     <= 1'b0;
         bSpec_q     <= 1'b0;
         kR_q        <= UNITY_GAIN;
         kB_q        <= UNITY_GAIN;
         validGain_q <= 1'b0;
         gainUpd_q   <= 1'b0;
         statDrop_q  <= 1'b0;
      end else begin
         gainUpd_q  <= 1'b0;
         statDrop_q <= eofAcc && (state_q != ACCUM);
         if (state_q == CHK_R) begin
            rSpec_q <= chkZero | chkSat;
            rRes_q  <= specialGain(chkZero);
         end
         if (state_q == CHK_B) begin
            bSpec_q <= chkZero | chkSat;
            bRes_q  <= specialGain(chkZero);
            if (!rSpec_q) rRes_q <= divQuot;
         end
         if (state_q == PUBLISH) begin
            kR_q        <= rRes_q;
            kB_q        <= bSpec_q ? bRes_q : divQuot;
            validGain_q <= 1'b1;
            gainUpd_q   <= 1'b1;
         end
      end
   end

   assign k_r_o        = kR_q;
   assign k_g_o        = UNITY_GAIN;
   assign k_b_o        = kB_q;
   assign valid_gain_o = validGain_q;
   assign gain_upd_o   = gainUpd_q;
   assign busy_o       = (state_q != ACCUM);
   assign stat_drop_o  = statDrop_q;

endmodule

// File: tb/tb_awb_gain_gen.sv
// Scoreboard bench for awb_gain_gen: the stimulus side predicts publications and drops
// from frame arithmetic, and a per-cycle monitor checks every output against those predictions.
module tb_awb_gain_gen;

   localparam int SUM_W   = 12;
   localparam int G_SHIFT = 1;
   localparam int SAT     = (1 << SUM_W) - 1;
   localparam int LAT     = 19;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       valid_i = 1'b0;
   logic [1:0] color_i = 2'd0;
   logic [7:0] value_i = 8'd0;
   logic       eof_i = 1'b0;
   logic [7:0] k_r_o, k_g_o, k_b_o;
   logic       valid_gain_o, gain_upd_o, busy_o, stat_drop_o;

   awb_gain_gen #(.SUM_W(SUM_W), .G_SHIFT(G_SHIFT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_i      (valid_i),
      .color_i      (color_i),
      .value_i      (value_i),
      .eof_i        (eof_i),
      .k_r_o        (k_r_o),
      .k_g_o        (k_g_o),
      .k_b_o        (k_b_o),
      .valid_gain_o (valid_gain_o),
      .gain_upd_o   (gain_upd_o),
      .busy_o       (busy_o),
      .stat_drop_o  (stat_drop_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         t;
      logic [7:0] kr;
      logic [7:0] kb;
   } pub_t;

   pub_t       pubQ[$];
   int         dropQ[$];
   int         sumR = 0, sumG = 0, sumB = 0;
   int         lastSnap = 0;
   bit         haveSnap = 1'b0;
   logic [7:0] curKR = 8'h10, curKB = 8'h10;
   bit         expValid = 1'b0;
   bit         inReset = 1'b1;
   int         nChecks = 0, nFails = 0;

   task automatic checkOutput(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Gain as the ratio of green to channel sums in Q4.4, clipped to 8 bits; no data means unity.
   function automatic logic [7:0] refGain(input int gs, input int d);
      longint q;
      if (d == 0) return 8'h10;
      q = (longint'(gs) * 16) / d;
      if (q > 255) q = 255;
      return 8'(q);
   endfunction

   function automatic int satSum(input int a, input int v);
      return (a + v > SAT) ? SAT : a + v;
   endfunction

   task automatic applyStimulus(input bit v, input int color, input int value, input bit eof);
      int e;
      int gs;
      pub_t p;
      @(negedge clk);
      valid_i = v;
      color_i = color[1:0];
      value_i = value[7:0];
      eof_i   = eof;
      if (v) begin
         if (color[1:0] == 2'd0) sumR = satSum(sumR, value[7:0]);
         if (color[1:0] == 2'd1) sumG = satSum(sumG, value[7:0]);
         if (color[1:0] == 2'd2) sumB = satSum(sumB, value[7:0]);
         if (eof) begin
            e = cyc + 1;
            if (haveSnap && e > lastSnap && e <= lastSnap + LAT) begin
               dropQ.push_back(e);
            end else begin
               gs   = sumG >> G_SHIFT;
               p.t  = e + LAT;
               p.kr = refGain(gs, sumR);
               p.kb = refGain(gs, sumB);
               pubQ.push_back(p);
               lastSnap = e;
               haveSnap = 1'b1;
            end
            sumR = 0;
            sumG = 0;
            sumB = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom_range(0, 3), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
   endtask

   task automatic doReset(input int hold);
      @(negedge clk);
      #2;
      inReset  = 1'b1;
      rst_n    = 1'b0;
      valid_i  = 1'b0;
      eof_i    = 1'b0;
      pubQ.delete();
      dropQ.delete();
      sumR     = 0;
      sumG     = 0;
      sumB     = 0;
      haveSnap = 1'b0;
      curKR    = 8'h10;
      curKB    = 8'h10;
      expValid = 1'b0;
      #1;
      checkOutput("reset k_r", k_r_o, 8'h10);
      checkOutput("reset k_g", k_g_o, 8'h10);
      checkOutput("reset k_b", k_b_o, 8'h10);
      checkOutput("reset valid_gain", valid_gain_o, 0);
      checkOutput("reset gain_upd", gain_upd_o, 0);
      checkOutput("reset busy", busy_o, 0);
      checkOutput("reset stat_drop", stat_drop_o, 0);
      repeat (hold) @(negedge clk);
      #2;
      rst_n   = 1'b1;
      inReset = 1'b0;
   endtask

   // Monitor: pops the scoreboard when a publication or drop is due and checks all outputs every cycle.
   initial begin
      bit   expUpd, expDrop, expBusy;
      pub_t p;
      forever begin
         @(negedge clk);
         if (!inReset) begin
            expUpd = (pubQ.size() > 0) && (pubQ[0].t == cyc);
            if (expUpd) begin
               p        = pubQ.pop_front();
               curKR    = p.kr;
               curKB    = p.kb;
               expValid = 1'b1;
            end
            expDrop = (dropQ.size() > 0) && (dropQ[0] == cyc);
            if (expDrop) void'(dropQ.pop_front());
            expBusy = haveSnap && (cyc >= lastSnap) && (cyc <= lastSnap + LAT - 1);
            checkOutput("gain_upd", gain_upd_o, expUpd);
            checkOutput("stat_drop", stat_drop_o, expDrop);
            checkOutput("busy", busy_o, expBusy);
            checkOutput("valid_gain", valid_gain_o, expValid);
            checkOutput("k_r", k_r_o, curKR);
            checkOutput("k_g", k_g_o, 8'h10);
            checkOutput("k_b", k_b_o, curKB);
         end
      end
   end

   initial begin
      int n;
      bit v;
      int snapAt;

      doReset(3);
      idle(2);

      // Reference frame: expect K_R=0x20, K_B=0x40.
      applyStimulus(1, 0, 64, 0);
      applyStimulus(1, 1, 128, 0);
      applyStimulus(1, 1, 128, 0);
      applyStimulus(1, 2, 32, 1);
      idle(25);

      // No red: zero divisor gives unity red gain, K_B=0x20.
      applyStimulus(1, 1, 100, 0);
      applyStimulus(1, 1, 100, 0);
      applyStimulus(1, 2, 50, 1);
      idle(25);

      // Tiny red saturates K_R at 0xFF, K_B lands exactly on unity.
      applyStimulus(1, 0, 1, 0);
      applyStimulus(1, 1, 255, 0);
      applyStimulus(1, 1, 255, 0);
      applyStimulus(1, 2, 255, 1);
      idle(25);

      // Reference frame with reserved-channel and invalid samples mixed in.
      applyStimulus(1, 3, 200, 0);
      applyStimulus(1, 0, 64, 0);
      applyStimulus(0, 0, 99, 1);
      applyStimulus(1, 1, 128, 0);
      applyStimulus(1, 3, 77, 0);
      applyStimulus(0, 2, 5, 0);
      applyStimulus(1, 1, 128, 0);
      applyStimulus(1, 2, 32, 1);
      idle(25);

      // Second eof five cycles after the first is dropped; the next full frame computes.
      applyStimulus(1, 0, 50, 0);
      applyStimulus(1, 1, 200, 0);
      applyStimulus(1, 2, 40, 1);
      idle(4);
      applyStimulus(1, 0, 10, 1);
      idle(25);
      applyStimulus(1, 0, 30, 0);
      applyStimulus(1, 1, 90, 0);
      applyStimulus(1, 2, 60, 1);
      idle(25);

      // Accumulator saturation on red and green.
      for (int i = 0; i < 20; i++) applyStimulus(1, 0, 255, 0);
      for (int i = 0; i < 20; i++) applyStimulus(1, 1, 255, 0);
      applyStimulus(1, 2, 255, 1);
      idle(25);

      // Reset lands mid DIV_B; the interrupted gains must never appear.
      applyStimulus(1, 0, 70, 0);
      applyStimulus(1, 1, 180, 0);
      applyStimulus(1, 2, 45, 1);
      snapAt = lastSnap;
      while (cyc < snapAt + 13) idle(1);
      doReset(2);
      idle(3);
      applyStimulus(1, 0, 64, 0);
      applyStimulus(1, 1, 128, 0);
      applyStimulus(1, 1, 128, 0);
      applyStimulus(1, 2, 32, 1);
      idle(25);

      // Random frames with random gaps, so some eofs fall inside the busy window.
      for (int f = 0; f < 40; f++) begin
         n = $urandom_range(1, 10);
         for (int s = 0; s < n - 1; s++) begin
            v = ($urandom_range(0, 3) != 0);
            applyStimulus(v, $urandom_range(0, 3), $urandom_range(0, 255), v ? 1'b0 : 1'($urandom_range(0, 1)));
         end
         applyStimulus(1, $urandom_range(0, 3), $urandom_range(0, 255), 1);
         idle($urandom_range(0, 24));
      end

      idle(30);
      checkOutput("pending publications", pubQ.size(), 0);
      checkOutput("pending drops", dropQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
